// File: rtl/fluxripper_capture_pkg.sv
// fluxripper_capture_pkg: capture-sequencer state type, defaults and shared helpers.
// Revision 1.0
`default_nettype none

package fluxripper_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  localparam int REV_W_DEFAULT          = 8;
  localparam int TIMEOUT_CYCLES_DEFAULT = 100_000_000;  // 500 ms at 200 MHz

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/capture_watchdog.sv
// capture_watchdog: clearable 32-bit cycle counter with an expiry strobe at TIMEOUT_CYCLES-1.
// Revision 1.0
`default_nettype none

module capture_watchdog
  import fluxripper_capture_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 32'd0;
    end else if (enable) begin
      count <= sat_inc32(count);
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/index_capture_sequencer.sv
// index_capture_sequencer: gates flux capture on index-to-index boundaries of one drive.
// Revision 1.0
`default_nettype none

module index_capture_sequencer
  import fluxripper_capture_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int REV_W          = REV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       index_pulse,
  input  logic [1:0]       drive_sel,
  input  logic             start,
  input  logic             abort,
  input  logic [REV_W-1:0] num_revs,
  output logic             busy,
  output logic             capture_en,
  output logic             rev_marker,
  output logic [REV_W-1:0] rev_count,
  output logic [31:0]      capture_cycles,
  output logic             done,
  output logic             timeout_err,
  output logic             aborted
);

  cap_state_t       state, state_nxt;
  logic [1:0]       sel_q;
  logic [REV_W-1:0] revs_q;
  logic             sel_idx;
  logic             wd_expired;
  logic             accept, arm_hit, rev_hit;
  logic             end_abort, end_complete, end_timeout;
  logic [REV_W:0]   rev_next;

  assign sel_idx    = index_pulse[sel_q];
  assign busy       = (state != IDLE);
  assign capture_en = (state == CAPTURE);
  assign rev_next   = {1'b0, rev_count} + {{REV_W{1'b0}}, 1'b1};

  capture_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept | arm_hit | rev_hit),
    .enable (busy),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Priority in ARM/CAPTURE: abort, then index, then watchdog expiry.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    arm_hit      = 1'b0;
    rev_hit      = 1'b0;
    end_abort    = 1'b0;
    end_complete = 1'b0;
    end_timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (abort) begin
          end_abort = 1'b1;
        end else if (sel_idx) begin
          arm_hit   = 1'b1;
          state_nxt = CAPTURE;
        end else if (wd_expired) begin
          end_timeout = 1'b1;
        end
      end
      CAPTURE: begin
        if (abort) begin
          end_abort = 1'b1;
        end else if (sel_idx) begin
          rev_hit = 1'b1;
          if ((revs_q != '0) && (rev_next == {1'b0, revs_q})) begin
            end_complete = 1'b1;
          end
        end else if (wd_expired) begin
          end_timeout = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (end_abort || end_complete || end_timeout) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q          <= 2'd0;
      revs_q         <= '0;
      rev_marker     <= 1'b0;
      rev_count      <= '0;
      capture_cycles <= 32'd0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      rev_marker <= arm_hit | rev_hit;
      done       <= end_abort | end_complete | end_timeout;
      if (accept) begin
        sel_q          <= drive_sel;
        revs_q         <= num_revs;
        rev_count      <= '0;
        capture_cycles <= 32'd0;
        timeout_err    <= 1'b0;
        aborted        <= 1'b0;
      end else begin
        if (rev_hit && !rev_next[REV_W]) begin
          rev_count <= rev_next[REV_W-1:0];
        end
        if (capture_en) begin
          capture_cycles <= sat_inc32(capture_cycles);
        end
        if (end_abort) begin
          aborted <= 1'b1;
        end
        if (end_timeout) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_index_capture_sequencer.sv
// tb_index_capture_sequencer: vector table plus directed multi-cycle sequences.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_index_capture_sequencer;

  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  index_pulse;
  logic [1:0]  drive_sel;
  logic        start;
  logic        abort;
  logic [7:0]  num_revs;
  logic        busy, capture_en, rev_marker, done, timeout_err, aborted;
  logic [7:0]  rev_count;
  logic [31:0] capture_cycles;

  always #5 clk = ~clk;

  index_capture_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .REV_W(8)
  ) dut (
    .clk(clk), .reset(reset), .index_pulse(index_pulse), .drive_sel(drive_sel),
    .start(start), .abort(abort), .num_revs(num_revs), .busy(busy),
    .capture_en(capture_en), .rev_marker(rev_marker), .rev_count(rev_count),
    .capture_cycles(capture_cycles), .done(done), .timeout_err(timeout_err),
    .aborted(aborted)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  idx;
    logic [1:0]  dsel;
    logic        st;
    logic        ab;
    logic [7:0]  nrev;
    logic        busy;
    logic        cen;
    logic        mark;
    logic        done;
    logic [7:0]  rc;
    logic [31:0] cc;
    logic        terr;
    logic        abt;
  } vec_t;

  vec_t tbl [19];
  int vectors = 0;
  int miscompares = 0;
  int mark_cnt, done_cnt, cen_cnt;

  function automatic logic [45:0] outs();
    return {busy, capture_en, rev_marker, done, rev_count, capture_cycles, timeout_err, aborted};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    mark_cnt = 0;
    done_cnt = 0;
    cen_cnt  = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rev_marker) mark_cnt++;
    if (done)       done_cnt++;
    if (capture_en) cen_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic idx_tick(input logic [3:0] mask);
    index_pulse = mask;
    cyc();
    index_pulse = 4'd0;
  endtask

  task automatic begin_capture(input logic [1:0] d, input logic [7:0] n);
    drive_sel = d;
    num_revs  = n;
    start     = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int done_at;
    reset = 1'b1; index_pulse = 4'd0; drive_sel = 2'd0; start = 1'b0; abort = 1'b0; num_revs = 8'd0;
    clr_cnt();

    //         rst idx    dsel st ab nrev  busy cen mk dn rc  cc     terr abt
    tbl[0]  = '{1, 4'h0, 2'd0, 0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 32'd0, 0, 0};
    tbl[1]  = '{0, 4'h0, 2'd0, 0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 32'd0, 0, 0};
    tbl[2]  = '{0, 4'h0, 2'd0, 0, 1, 8'd0, 0, 0, 0, 0, 8'd0, 32'd0, 0, 0};
    tbl[3]  = '{0, 4'h0, 2'd1, 1, 1, 8'd2, 1, 0, 0, 0, 8'd0, 32'd0, 0, 0};
    tbl[4]  = '{0, 4'h1, 2'd2, 0, 0, 8'd0, 1, 0, 0, 0, 8'd0, 32'd0, 0, 0};
    tbl[5]  = '{0, 4'h2, 2'd2, 0, 0, 8'd0, 1, 1, 1, 0, 8'd0, 32'd0, 0, 0};
    tbl[6]  = '{0, 4'h0, 2'd2, 0, 0, 8'd0, 1, 1, 0, 0, 8'd0, 32'd1, 0, 0};
    tbl[7]  = '{0, 4'h2, 2'd2, 0, 0, 8'd0, 1, 1, 1, 0, 8'd1, 32'd2, 0, 0};
    tbl[8]  = '{0, 4'h0, 2'd2, 0, 0, 8'd0, 1, 1, 0, 0, 8'd1, 32'd3, 0, 0};
    tbl[9]  = '{0, 4'h2, 2'd2, 0, 0, 8'd0, 0, 0, 1, 1, 8'd2, 32'd4, 0, 0};
    tbl[10] = '{0, 4'h0, 2'd2, 0, 0, 8'd0, 0, 0, 0, 0, 8'd2, 32'd4, 0, 0};
    tbl[11] = '{0, 4'h0, 2'd3, 1, 0, 8'd0, 1, 0, 0, 0, 8'd0, 32'd0, 0, 0};
    tbl[12] = '{0, 4'h8, 2'd0, 0, 0, 8'd0, 1, 1, 1, 0, 8'd0, 32'd0, 0, 0};
    tbl[13] = '{0, 4'h8, 2'd0, 0, 1, 8'd0, 0, 0, 0, 1, 8'd0, 32'd1, 0, 1};
    tbl[14] = '{0, 4'h0, 2'd0, 0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 32'd1, 0, 1};
    tbl[15] = '{0, 4'h0, 2'd0, 1, 0, 8'd1, 1, 0, 0, 0, 8'd0, 32'd0, 0, 0};
    tbl[16] = '{0, 4'h1, 2'd0, 0, 0, 8'd0, 1, 1, 1, 0, 8'd0, 32'd0, 0, 0};
    tbl[17] = '{0, 4'h1, 2'd0, 0, 0, 8'd0, 0, 0, 1, 1, 8'd1, 32'd1, 0, 0};
    tbl[18] = '{0, 4'h1, 2'd0, 0, 0, 8'd0, 0, 0, 0, 0, 8'd1, 32'd1, 0, 0};

    for (int i = 0; i < 19; i++) begin
      reset = tbl[i].rst; index_pulse = tbl[i].idx; drive_sel = tbl[i].dsel;
      start = tbl[i].st;  abort = tbl[i].ab;        num_revs = tbl[i].nrev;
      cyc();
      chk($sformatf("table_row%0d", i), 64'(outs()),
          64'({tbl[i].busy, tbl[i].cen, tbl[i].mark, tbl[i].done, tbl[i].rc,
               tbl[i].cc, tbl[i].terr, tbl[i].abt}));
    end
    reset = 1'b0; index_pulse = 4'd0; start = 1'b0; abort = 1'b0;
    idle(2);

    // Drive 2, three revolutions at 400 clocks, with a stray start/drive change mid-capture.
    clr_cnt();
    begin_capture(2'd2, 8'd3);
    drive_sel = 2'd0; num_revs = 8'd1;
    idle(49);
    idx_tick(4'b0100);
    idle(99);
    start = 1'b1; cyc(); start = 1'b0;
    idle(100);
    idx_tick(4'b0001);
    idle(198);
    idx_tick(4'b0100); idle(399);
    idx_tick(4'b0100); idle(399);
    idx_tick(4'b0100);
    chk("rev3_end_done", 64'({done, capture_en, busy}), 64'(3'b100));
    idle(5);
    chk("rev3_markers", 64'(mark_cnt), 64'd4);
    chk("rev3_cen_cycles", 64'(cen_cnt), 64'd1200);
    chk("rev3_capture_cycles", 64'(capture_cycles), 64'd1200);
    chk("rev3_rev_count", 64'(rev_count), 64'd3);
    chk("rev3_done_cnt", 64'(done_cnt), 64'd1);
    chk("rev3_flags", 64'({timeout_err, aborted}), 64'd0);

    // Only unselected drives pulse: ARM times out after TO cycles.
    clr_cnt();
    done_at = -1;
    begin_capture(2'd2, 8'd3);
    for (int k = 1; k <= 1100; k++) begin
      index_pulse = (k % 7 == 0) ? 4'b1011 : 4'b0000;
      cyc();
      if (done && done_at < 0) done_at = k;
    end
    index_pulse = 4'd0;
    chk("unsel_done_at", 64'(done_at), 64'd1000);
    chk("unsel_timeout_err", 64'(timeout_err), 64'd1);
    chk("unsel_markers", 64'(mark_cnt), 64'd0);
    chk("unsel_cen", 64'(cen_cnt), 64'd0);
    chk("unsel_done_cnt", 64'(done_cnt), 64'd1);

    // Continuous capture, ten revolutions, then abort.
    clr_cnt();
    begin_capture(2'd1, 8'd0);
    idle(20);
    for (int r = 0; r < 11; r++) begin
      idx_tick(4'b0010);
      if (r < 10) idle(399);
    end
    idle(50);
    chk("cont_cen_before_abort", 64'(capture_en), 64'd1);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("cont_abort_edge", 64'({capture_en, done, aborted, busy}), 64'(4'b0110));
    idle(3);
    chk("cont_rev_count", 64'(rev_count), 64'd10);
    chk("cont_counts", 64'({mark_cnt[15:0], done_cnt[15:0]}), 64'({16'd11, 16'd1}));
    chk("cont_timeout_err", 64'(timeout_err), 64'd0);

    // Abort coincides with the second in-capture index.
    clr_cnt();
    begin_capture(2'd3, 8'd0);
    idle(5);
    idx_tick(4'b1000); idle(9);
    idx_tick(4'b1000); idle(9);
    index_pulse = 4'b1000; abort = 1'b1; cyc(); index_pulse = 4'd0; abort = 1'b0;
    chk("abort_idx_edge", 64'({rev_marker, done, aborted, rev_count}), 64'({3'b011, 8'd1}));
    idle(2);
    chk("abort_idx_markers", 64'(mark_cnt), 64'd2);

    // Index exactly at watchdog expiry wins; one cycle later the watchdog fires.
    clr_cnt();
    begin_capture(2'd0, 8'd0);
    idle(10);
    idx_tick(4'b0001);
    idle(999);
    idx_tick(4'b0001);
    chk("limit_index_wins", 64'({rev_marker, done, capture_en, timeout_err, rev_count}),
        64'({4'b1010, 8'd1}));
    done_at = -1;
    for (int k = 1; k <= 1001; k++) begin
      cyc();
      if (done && done_at < 0) done_at = k;
    end
    idx_tick(4'b0001);
    chk("limit_timeout_at", 64'(done_at), 64'd1000);
    chk("limit_timeout_flags", 64'({timeout_err, aborted, capture_en, rev_count}),
        64'({3'b100, 8'd1}));
    chk("limit_done_cnt", 64'(done_cnt), 64'd1);

    // Reset mid-capture, landing on a selected index.
    clr_cnt();
    begin_capture(2'd1, 8'd5);
    idle(3);
    idx_tick(4'b0010);
    idle(10);
    reset = 1'b1; index_pulse = 4'b0010; cyc(); reset = 1'b0; index_pulse = 4'd0;
    chk("reset_mid_outputs", 64'(outs()), 64'd0);
    clr_cnt();
    for (int k = 0; k < 20; k++) idx_tick((k % 4 == 0) ? 4'b0010 : 4'b0000);
    chk("reset_after_quiet", 64'({done_cnt[15:0], mark_cnt[15:0], cen_cnt[15:0]}), 64'd0);
    chk("reset_after_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
